// File: rtl/datain_buf_ctrl_pkg.sv
//----------------------------------------------------------------------------
// Module   : datain_buf_ctrl_pkg
// Purpose  : Shared constants and state encoding for the input-sample
//            buffer controller (block size, RAM address/data widths,
//            default requester count, controller state type).
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package datain_buf_ctrl_pkg;

    localparam int C_DEPTH   = 30;   // words per block / RAM entries
    localparam int C_AW      = 5;    // RAM address width
    localparam int C_DW      = 20;   // data word width
    localparam int C_NUM_REQ = 4;    // replay requesters

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

endpackage : datain_buf_ctrl_pkg

`default_nettype wire

// File: rtl/datain_buf_ctrl_rr_arbiter.sv
//----------------------------------------------------------------------------
// Module   : datain_buf_ctrl_rr_arbiter
// Purpose  : Combinational round-robin arbiter. Grants the first asserted
//            request at or after ptr+1 (mod NUM_REQ). The pointer itself
//            is held by the parent.
// Ports    : req      in  NUM_REQ  request vector
//            ptr      in  PW       index of the most recent grant
//            enable   in  1        allow a grant this cycle
//            gnt_next out NUM_REQ  one-hot grant (all zero when disabled)
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module datain_buf_ctrl_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt_next
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    // Search starts one past the last winner, so the last winner is
    // examined last and every requester gets a turn.
    always_comb begin
        gnt_next = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = PW'((int'(ptr) + i) % NUM_REQ);
            if (enable && !w_found && req[w_idx]) begin
                gnt_next[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

endmodule : datain_buf_ctrl_rr_arbiter

`default_nettype wire

// File: rtl/datain_buf_ctrl.sv
//----------------------------------------------------------------------------
// Module   : datain_buf_ctrl
// Purpose  : Sequencer for the single-port input-sample buffer RAM.
//            Loads one block of DEPTH words from the upstream stream, then
//            replays the stored block as full bursts to NUM_REQ consumers
//            under round-robin arbitration.
// Ports    : clk       in   1        system clock, rising edge
//            RST       in   1        synchronous active-high reset
//            in_valid  in   1        upstream word valid
//            in_ready  out  1        word accepted this cycle
//            datain    in   DW       upstream word
//            clear     in   1        discard stored block (READY only)
//            req       in   NUM_REQ  replay requests (level)
//            gnt       out  NUM_REQ  one-hot grant, held for the burst
//            ram_addr  out  AW       RAM address
//            ram_we    out  1        RAM write enable
//            ram_din   out  DW       RAM write data
//            ram_dout  in   DW       RAM read data (1-cycle latency)
//            out_valid out  1        replay word valid
//            out_data  out  DW       replay word
//            out_last  out  1        final word of burst
//            loaded    out  1        complete block stored
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module datain_buf_ctrl
    import datain_buf_ctrl_pkg::*;
#(
    parameter int DEPTH   = C_DEPTH,
    parameter int AW      = C_AW,
    parameter int DW      = C_DW,
    parameter int NUM_REQ = C_NUM_REQ
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      datain,
    input  logic               clear,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [AW-1:0]      ram_addr,
    output logic               ram_we,
    output logic [DW-1:0]      ram_din,
    input  logic [DW-1:0]      ram_dout,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic               out_last,
    output logic               loaded
);

    localparam int            PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t               r_state,     w_state_next;
    logic [AW-1:0]        r_count,     w_count_next;
    logic [AW-1:0]        r_addr,      w_addr_next;
    logic [NUM_REQ-1:0]   r_gnt,       w_gnt_next;
    logic [PW-1:0]        r_ptr,       w_ptr_next;
    logic                 r_out_valid, w_out_valid_next;
    logic                 r_out_last,  w_out_last_next;
    logic                 r_loaded,    w_loaded_next;

    logic                 w_accept;
    logic                 w_arb_en;
    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic [PW-1:0]        w_arb_idx;

    //------------------------------------------------------------------
    // Write path is combinational so the first word presented in EMPTY
    // lands at address 0 in the same cycle it is accepted.
    //------------------------------------------------------------------
    assign in_ready = (r_state == ST_EMPTY) || (r_state == ST_LOAD);
    assign w_accept = in_valid && in_ready;
    assign ram_we   = w_accept;
    assign ram_din  = datain;

    // RAM output is already registered inside the RAM; forward as-is.
    assign out_data  = ram_dout;
    assign ram_addr  = r_addr;
    assign gnt       = r_gnt;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign loaded    = r_loaded;

    // clear wins over any request while READY.
    assign w_arb_en = (r_state == ST_READY) && !clear;

    datain_buf_ctrl_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_arb (
        .req      (req),
        .ptr      (r_ptr),
        .enable   (w_arb_en),
        .gnt_next (w_arb_gnt)
    );

    always_comb begin
        w_arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_arb_idx = PW'(i);
            end
        end
    end

    //------------------------------------------------------------------
    // Next-state and next-output logic
    //------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_addr_next      = r_addr;
        w_gnt_next       = r_gnt;
        w_ptr_next       = r_ptr;
        w_out_valid_next = 1'b0;
        w_out_last_next  = 1'b0;
        w_loaded_next    = r_loaded;

        case (r_state)
            ST_EMPTY, ST_LOAD: begin
                if (w_accept) begin
                    if (r_count == LAST_ADDR) begin
                        w_count_next  = '0;
                        w_addr_next   = '0;
                        w_loaded_next = 1'b1;
                        w_state_next  = ST_READY;
                    end else begin
                        w_count_next  = r_count + AW'(1);
                        w_addr_next   = r_count + AW'(1);
                        w_state_next  = ST_LOAD;
                    end
                end
            end

            ST_READY: begin
                if (clear) begin
                    w_loaded_next = 1'b0;
                    w_count_next  = '0;
                    w_addr_next   = '0;
                    w_state_next  = ST_EMPTY;
                end else if (|w_arb_gnt) begin
                    w_gnt_next   = w_arb_gnt;
                    w_ptr_next   = w_arb_idx;
                    w_addr_next  = '0;
                    w_state_next = ST_PLAY;
                end
            end

            ST_PLAY: begin
                // Data for the address issued now is valid next cycle.
                w_out_valid_next = 1'b1;
                if (r_addr == LAST_ADDR) begin
                    w_out_last_next = 1'b1;
                    w_addr_next     = '0;
                    w_state_next    = ST_DRAIN;
                end else begin
                    w_addr_next     = r_addr + AW'(1);
                end
            end

            ST_DRAIN: begin
                w_gnt_next   = '0;
                w_state_next = ST_READY;
            end

            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    //------------------------------------------------------------------
    // State and output registers
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state     <= ST_EMPTY;
            r_count     <= '0;
            r_addr      <= '0;
            r_gnt       <= '0;
            r_ptr       <= PW'(NUM_REQ - 1);
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_loaded    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_addr      <= w_addr_next;
            r_gnt       <= w_gnt_next;
            r_ptr       <= w_ptr_next;
            r_out_valid <= w_out_valid_next;
            r_out_last  <= w_out_last_next;
            r_loaded    <= w_loaded_next;
        end
    end

endmodule : datain_buf_ctrl

`default_nettype wire

// File: doc/datain_buf_ctrl.md
Name: datain_buf_ctrl

Overview:
Sequences the 30-entry, 20-bit single-port input-sample buffer RAM (1-cycle read latency). It runs one load phase of DEPTH words from the upstream in_valid/datain stream. It then shares replay of the stored block among NUM_REQ consumers, using round-robin arbitration with one full DEPTH-word burst per grant. It owns the RAM address, write enable and write data, and sits between the input stage and the downstream processing consumers.

Parameters:
DEPTH, 30, words per block / RAM entries
AW, 5, RAM address width (ceil(log2(DEPTH)))
DW, 20, data word width
NUM_REQ, 4, number of replay requesters

Ports:
clk  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
in_valid  in  1  upstream word valid
in_ready  out  1  controller accepts a word this cycle
datain  in  DW  upstream word
clear  in  1  discard the stored block and return to empty
req  in  NUM_REQ  per-consumer replay request (level)
gnt  out  NUM_REQ  one-hot grant, held for the whole burst
ram_addr  out  AW  RAM address
ram_we  out  1  RAM write enable
ram_din  out  DW  RAM write data (= datain)
ram_dout  in  DW  RAM read data, valid 1 cycle after ram_addr
out_valid  out  1  replay word valid
out_data  out  DW  replay word (= ram_dout)
out_last  out  1  final word of the burst
loaded  out  1  a complete block is stored

Behaviour:
- Clock is clk; reset is RST, synchronous and active-high.
- Reset values: state=EMPTY, ram_addr=0, count=0, gnt=0, out_valid=0, out_last=0, loaded=0, RR pointer=NUM_REQ-1 (req[0] has first priority).
- An RST assertion at any point, including mid-load or mid-burst, aborts the operation. All state returns to reset values on the next edge.
- Outputs are registered, except in_ready, ram_we and ram_din, which are combinational from state and inputs.
- States and transitions:
  - EMPTY: in_ready=1. On the first accepted word (in_valid&in_ready), go to LOAD.
  - LOAD: in_ready=1. ram_we=in_valid, and ram_addr=count.
    - The write index count increments on each accepted write.
    - Gaps in in_valid stall the load without loss.
    - The write at count==DEPTH-1 sets loaded=1, resets count to 0 and moves to READY.
  - READY: in_ready=0, so extra upstream words are not accepted.
    - If clear=1, go to EMPTY and set loaded=0. clear has priority over any req.
    - Otherwise, if req!=0, grant the first set bit at or after ptr+1 (mod NUM_REQ). Registered gnt goes one-hot, ptr is set to the granted index, ram_addr=0, and the state goes to PLAY.
  - PLAY: ram_addr steps 0..DEPTH-1 on successive cycles.
    - out_valid is asserted one cycle after each address is issued.
    - After address DEPTH-1, go to DRAIN.
  - DRAIN: presents the last word with out_valid=1 and out_last=1, then returns to READY with gnt=0.
- Timing: if req is sampled in READY at edge T:
  - gnt is high from cycle T+1 through T+DEPTH+1 inclusive.
  - out_data words 0..DEPTH-1 appear on cycles T+2..T+DEPTH+1.
  - The earliest next grant is at T+DEPTH+3.
- Back-to-back bursts leave one idle READY cycle between them.
- req deassertion during a burst does not truncate it. clear during EMPTY, LOAD, PLAY or DRAIN is ignored and not latched.
- The address never exceeds DEPTH-1. Wrap is explicit at DEPTH-1, not at 2^AW.
- A new load after clear overwrites all DEPTH entries. Old contents are never replayed.

Decomposition:
- Shared package: DEPTH, AW, DW constants, plus the state encoding (EMPTY, LOAD, READY, PLAY, DRAIN).
- One sub-module, rr_arbiter (NUM_REQ-wide):
  - inputs: req, ptr, enable
  - output: one-hot gnt_next
  - combinational, with the pointer held in the parent
- The RAM itself is instantiated outside this block.

Test Plan:
- Load 30 words 0x00000..0x0001D with in_valid held high -> ram_we high 30 cycles, ram_addr 0..29, loaded=1 the cycle after the 30th write, in_ready=0 thereafter.
- Load with in_valid toggling 1/0 -> 30 writes over 59 cycles, no address skipped or repeated.
- req=4'b0010 in READY -> gnt=0010 for 31 cycles; out_data 0x00000..0x0001D on consecutive cycles; out_last with 0x0001D; then gnt=0.
- req=4'b1111 held -> grant order 0,1,2,3,0, each a full 30-word burst separated by one idle cycle.
- clear and req=0001 in the same READY cycle -> no grant, state EMPTY, loaded=0. Reload with 0xABC00+i then replay -> new data only.
- RST asserted at word 12 of a burst -> next cycle gnt=0, out_valid=0, loaded=0, in_ready=1, ram_addr=0.
